sha2_issue_ctrl: RTL and testbench

- Sequential issue/writeback stage wrapped around the combinational sha2_unit in the ibex-crypto datapath.
- Accepts SHA-2 requests from ID/EX over a valid/ready handshake, registers the operands, drives sha2_unit, and registers the result toward writeback.
- Optionally fuses an RV32 SHA-512 low/high instruction pair into one request that produces a full 64-bit result over two cycles, reusing the single sha2_unit.

---
 rtl/ibex_pkg.sv | 39 +++
 rtl/sha2_unit.sv | 42 ++++
 rtl/sha2_issue_ctrl.sv | 160 ++++++++++++++++
 tb/tb_sha2_issue_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_pkg.sv
// Shared ibex-crypto types for the SHA-2 issue stage: op encoding, issue FSM states
// and the helpers that pair RV32 SHA-512 low/high instructions.
package ibex_pkg;

    typedef enum logic [3:0] {
        SHA2_SIG0  = 4'd0,
        SHA2_SIG1  = 4'd1,
        SHA2_SUM0  = 4'd2,
        SHA2_SUM1  = 4'd3,
        SHA2_SIG0L = 4'd4,
        SHA2_SIG0H = 4'd5,
        SHA2_SIG1L = 4'd6,
        SHA2_SIG1H = 4'd7,
        SHA2_SUM0R = 4'd8,
        SHA2_SUM1R = 4'd9
    } sha2_op_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CALC_LO = 2'd1,
        CALC_HI = 2'd2,
        RESP    = 2'd3
    } sha2_issue_state_e;

    // Op that yields the high word of a fused pair; the rotate-only ops are symmetric.
    function automatic sha2_op_t sha2_hi_op(input sha2_op_t op);
        case (op)
            SHA2_SIG0L: return SHA2_SIG0H;
            SHA2_SIG1L: return SHA2_SIG1H;
            default:    return op;
        endcase
    endfunction

    function automatic logic sha2_fusable(input sha2_op_t op);
        return (op == SHA2_SIG0L) || (op == SHA2_SIG1L) ||
               (op == SHA2_SUM0R) || (op == SHA2_SUM1R);
    endfunction

endpackage

// File: rtl/sha2_unit.sv
// Combinational SHA-256 sigma/sum and RV32 SHA-512 half-word functions.
// Output is forced to zero while sha2_en_i is low so idle operands do not toggle the XOR tree.
module sha2_unit
    import ibex_pkg::*;
(
    input  logic        sha2_en_i,
    input  sha2_op_t    op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] result_o
);

    function automatic logic [31:0] ror32(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    always_comb begin
        result_o = '0;
        if (sha2_en_i) begin
            case (op_i)
                SHA2_SIG0:  result_o = ror32(a_i, 7) ^ ror32(a_i, 18) ^ (a_i >> 3);
                SHA2_SIG1:  result_o = ror32(a_i, 17) ^ ror32(a_i, 19) ^ (a_i >> 10);
                SHA2_SUM0:  result_o = ror32(a_i, 2) ^ ror32(a_i, 13) ^ ror32(a_i, 22);
                SHA2_SUM1:  result_o = ror32(a_i, 6) ^ ror32(a_i, 11) ^ ror32(a_i, 25);
                SHA2_SIG0L: result_o = (a_i >> 1) ^ (a_i >> 7) ^ (a_i >> 8) ^
                                       (b_i << 31) ^ (b_i << 25) ^ (b_i << 24);
                SHA2_SIG0H: result_o = (a_i >> 1) ^ (a_i >> 7) ^ (a_i >> 8) ^
                                       (b_i << 31) ^ (b_i << 24);
                SHA2_SIG1L: result_o = (a_i << 3) ^ (a_i >> 6) ^ (a_i >> 19) ^
                                       (b_i >> 29) ^ (b_i << 26) ^ (b_i << 13);
                SHA2_SIG1H: result_o = (a_i << 3) ^ (a_i >> 6) ^ (a_i >> 19) ^
                                       (b_i >> 29) ^ (b_i << 13);
                SHA2_SUM0R: result_o = (a_i << 25) ^ (a_i << 30) ^ (a_i >> 28) ^
                                       (b_i >> 7) ^ (b_i >> 2) ^ (b_i << 4);
                SHA2_SUM1R: result_o = (a_i << 23) ^ (a_i >> 14) ^ (a_i >> 18) ^
                                       (b_i >> 9) ^ (b_i << 18) ^ (b_i << 14);
                default:    result_o = '0;
            endcase
        end
    end

endmodule

// File: rtl/sha2_issue_ctrl.sv
// Registered issue/writeback stage around sha2_unit with a valid/ready request and response.
// Define SHA2_ISSUE_FUSE_EN to fuse RV32 SHA-512 lo/hi pairs into one two-pass 64-bit request.
module sha2_issue_ctrl
    import ibex_pkg::*;
#(
    parameter bit BackToBack = 1'b1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               kill_i,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  ibex_pkg::sha2_op_t req_op_i,
    input  logic               req_fuse_i,
    input  logic [31:0]        op_a_i,
    input  logic [31:0]        op_b_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [31:0]        rsp_result_o,
    output logic [31:0]        rsp_result_hi_o
);

    sha2_issue_state_e state_q;
    sha2_op_t          op_q;
    logic [31:0]       a_q;
    logic [31:0]       b_q;
    logic [31:0]       res_lo_q;
    logic              rsp_valid_q;
    logic              accept;

    logic              unit_en;
    sha2_op_t          unit_op;
    logic [31:0]       unit_a;
    logic [31:0]       unit_b;
    logic [31:0]       unit_res;

`ifdef SHA2_ISSUE_FUSE_EN
    logic              fuse_q;
    logic [31:0]       res_hi_q;
`else
    logic              unused_fuse;
    assign unused_fuse = req_fuse_i;
`endif

    always_comb begin
        req_ready_o = 1'b0;
        case (state_q)
            IDLE:    req_ready_o = 1'b1;
            RESP:    req_ready_o = BackToBack & rsp_ready_i;
            default: req_ready_o = 1'b0;
        endcase
        if (kill_i) begin
            req_ready_o = 1'b0;
        end
    end

    // In RESP, ready already implies the response handshake, so accept doubles as it.
    assign accept = req_valid_i & req_ready_o;

    always_comb begin
        unit_en = 1'b0;
        unit_op = op_q;
        unit_a  = a_q;
        unit_b  = b_q;
        if (state_q == CALC_LO) begin
            unit_en = 1'b1;
        end
`ifdef SHA2_ISSUE_FUSE_EN
        if (state_q == CALC_HI) begin
            unit_en = 1'b1;
            unit_op = sha2_hi_op(op_q);
            unit_a  = b_q;
            unit_b  = a_q;
        end
`endif
    end

    sha2_unit u_sha2_unit (
        .sha2_en_i (unit_en),
        .op_i      (unit_op),
        .a_i       (unit_a),
        .b_i       (unit_b),
        .result_o  (unit_res)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            op_q        <= SHA2_SIG0;
            a_q         <= '0;
            b_q         <= '0;
            res_lo_q    <= '0;
            rsp_valid_q <= 1'b0;
`ifdef SHA2_ISSUE_FUSE_EN
            fuse_q      <= 1'b0;
            res_hi_q    <= '0;
`endif
        end else if (kill_i) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                op_q     <= req_op_i;
                a_q      <= op_a_i;
                b_q      <= op_b_i;
`ifdef SHA2_ISSUE_FUSE_EN
                fuse_q   <= req_fuse_i & sha2_fusable(req_op_i);
                res_hi_q <= '0;
`endif
            end
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= CALC_LO;
                    end
                end
                CALC_LO: begin
                    res_lo_q <= unit_res;
`ifdef SHA2_ISSUE_FUSE_EN
                    if (fuse_q) begin
                        state_q <= CALC_HI;
                    end else begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                    end
`else
                    state_q     <= RESP;
                    rsp_valid_q <= 1'b1;
`endif
                end
`ifdef SHA2_ISSUE_FUSE_EN
                CALC_HI: begin
                    res_hi_q    <= unit_res;
                    state_q     <= RESP;
                    rsp_valid_q <= 1'b1;
                end
`endif
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= accept ? CALC_LO : IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_result_o = res_lo_q;
`ifdef SHA2_ISSUE_FUSE_EN
    assign rsp_result_hi_o = res_hi_q;
`else
    assign rsp_result_hi_o = '0;
`endif

endmodule

// File: tb/tb_sha2_issue_ctrl.sv
// Bench for sha2_issue_ctrl: fixed vectors, hand sequences for back-to-back, kill and reset,
// and random ops checked against a 64-bit SHA-512/32-bit SHA-256 reference model.
`timescale 1ns/1ps
module tb_sha2_issue_ctrl;
    import ibex_pkg::*;

`ifdef SHA2_ISSUE_FUSE_EN
    localparam bit FuseEn = 1'b1;
`else
    localparam bit FuseEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, kill, req_valid, req_fuse, rsp_ready;
    sha2_op_t    req_op;
    logic [31:0] op_a, op_b;
    logic        req_ready, rsp_valid;
    logic [31:0] rsp_res, rsp_hi;
    logic        nb_req_valid, nb_req_ready, nb_rsp_valid;
    logic [31:0] nb_res, nb_hi;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    sha2_issue_ctrl #(.BackToBack(1'b1)) dut (
        .clk_i(clk), .rst_ni(rst_n), .kill_i(kill),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
        .req_fuse_i(req_fuse), .op_a_i(op_a), .op_b_i(op_b),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_result_o(rsp_res), .rsp_result_hi_o(rsp_hi)
    );

    sha2_issue_ctrl #(.BackToBack(1'b0)) dut_nb (
        .clk_i(clk), .rst_ni(rst_n), .kill_i(kill),
        .req_valid_i(nb_req_valid), .req_ready_o(nb_req_ready), .req_op_i(req_op),
        .req_fuse_i(req_fuse), .op_a_i(op_a), .op_b_i(op_b),
        .rsp_valid_o(nb_rsp_valid), .rsp_ready_i(1'b1),
        .rsp_result_o(nb_res), .rsp_result_hi_o(nb_hi)
    );

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] ror32(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction
    function automatic logic [63:0] s512_sig0(input logic [63:0] x);
        return ror64(x, 1) ^ ror64(x, 8) ^ (x >> 7);
    endfunction
    function automatic logic [63:0] s512_sig1(input logic [63:0] x);
        return ror64(x, 19) ^ ror64(x, 61) ^ (x >> 6);
    endfunction
    function automatic logic [63:0] s512_sum0(input logic [63:0] x);
        return ror64(x, 28) ^ ror64(x, 34) ^ ror64(x, 39);
    endfunction
    function automatic logic [63:0] s512_sum1(input logic [63:0] x);
        return ror64(x, 14) ^ ror64(x, 18) ^ ror64(x, 41);
    endfunction

    function automatic bit ref_fused(input sha2_op_t op, input logic fuse);
        return FuseEn && fuse &&
               (op inside {SHA2_SIG0L, SHA2_SIG1L, SHA2_SUM0R, SHA2_SUM1R});
    endfunction

    // {hi, lo}: L/R ops are the low word of the 64-bit function of {b,a}, H ops the high word of {a,b}.
    function automatic logic [63:0] ref_rsp(input sha2_op_t op, input logic fuse,
                                            input logic [31:0] a, input logic [31:0] b);
        logic [63:0] lh, hl, w;
        logic [31:0] lo, hi;
        lh = {b, a};
        hl = {a, b};
        lo = '0;
        hi = '0;
        w  = '0;
        case (op)
            SHA2_SIG0:  lo = ror32(a, 7) ^ ror32(a, 18) ^ (a >> 3);
            SHA2_SIG1:  lo = ror32(a, 17) ^ ror32(a, 19) ^ (a >> 10);
            SHA2_SUM0:  lo = ror32(a, 2) ^ ror32(a, 13) ^ ror32(a, 22);
            SHA2_SUM1:  lo = ror32(a, 6) ^ ror32(a, 11) ^ ror32(a, 25);
            SHA2_SIG0L: begin w = s512_sig0(lh); lo = w[31:0]; hi = w[63:32]; end
            SHA2_SIG1L: begin w = s512_sig1(lh); lo = w[31:0]; hi = w[63:32]; end
            SHA2_SUM0R: begin w = s512_sum0(lh); lo = w[31:0]; hi = w[63:32]; end
            SHA2_SUM1R: begin w = s512_sum1(lh); lo = w[31:0]; hi = w[63:32]; end
            SHA2_SIG0H: begin w = s512_sig0(hl); lo = w[63:32]; end
            SHA2_SIG1H: begin w = s512_sig1(hl); lo = w[63:32]; end
            default:    lo = '0;
        endcase
        if (!ref_fused(op, fuse)) hi = '0;
        return {hi, lo};
    endfunction

    // ---------------- drivers ----------------
    task automatic issue(input sha2_op_t op, input logic fuse, input logic [31:0] a,
                         input logic [31:0] b, output bit ok);
        int unsigned n = 0;
        req_valid = 1'b1; req_op = op; req_fuse = fuse; op_a = a; op_b = b;
        #1;
        while (!req_ready && n < 10) begin
            @(negedge clk); #1; n++;
        end
        ok = req_ready;
        @(negedge clk);
        // Scramble request inputs after accept; the registered operands must not follow.
        req_valid = 1'b0;
        req_op    = sha2_op_t'(4'($urandom_range(0, 9)));
        req_fuse  = 1'($urandom);
        op_a      = $urandom;
        op_b      = $urandom;
    endtask

    task automatic do_op(input string name, input sha2_op_t op, input logic fuse,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                         input int unsigned exp_lat, input int unsigned stall);
        bit ok;
        int unsigned n;
        rsp_ready = 1'b0;
        issue(op, fuse, a, b, ok);
        check($sformatf("%s accept", name), 32'(ok), 32'd1);
        if (!ok) return;
        n = 1;
        while (!rsp_valid && n < 8) begin
            @(negedge clk); n++;
        end
        check($sformatf("%s latency", name), n, exp_lat);
        if (!rsp_valid) return;
        check($sformatf("%s lo", name), rsp_res, exp_lo);
        check($sformatf("%s hi", name), rsp_hi, exp_hi);
        for (int unsigned s = 0; s < stall; s++) begin
            @(negedge clk);
            check($sformatf("%s stall valid", name), 32'(rsp_valid), 32'd1);
            check($sformatf("%s stall ready", name), 32'(req_ready), 32'd0);
            check($sformatf("%s stall lo", name), rsp_res, exp_lo);
        end
        rsp_ready = 1'b1;
        #1;
        check($sformatf("%s b2b ready", name), 32'(req_ready), 32'd1);
        @(negedge clk);
        rsp_ready = 1'b0;
        check($sformatf("%s done", name), 32'(rsp_valid), 32'd0);
    endtask

    task automatic b2b_seq(input bit nb);
        logic [6:0]  pat;
        int unsigned acc, nresp;
        logic        v, r;
        logic [31:0] res;
        pat = nb ? 7'b0100100 : 7'b0010100;
        rsp_ready = 1'b1; acc = 0; nresp = 0;
        req_op = SHA2_SIG0; req_fuse = 1'b0; op_b = '0;
        for (int c = 0; c < 7; c++) begin
            if (c > 0) @(negedge clk);
            v   = nb ? nb_rsp_valid : rsp_valid;
            res = nb ? nb_res : rsp_res;
            check($sformatf("b2b%0d valid c%0d", nb, c), 32'(v), 32'(pat[c]));
            if (v) begin
                check($sformatf("b2b%0d res%0d", nb, nresp), res,
                      (nresp == 0) ? 32'h02004000 : 32'h04008000);
                nresp++;
            end
            op_a = (acc == 0) ? 32'd1 : 32'd2;
            if (nb) nb_req_valid = (acc < 2);
            else    req_valid    = (acc < 2);
            #1;
            r = nb ? nb_req_ready : req_ready;
            if ((acc < 2) && r) acc++;
        end
        req_valid = 1'b0; nb_req_valid = 1'b0; rsp_ready = 1'b0;
        check($sformatf("b2b%0d accepts", nb), acc, 32'd2);
    endtask

    task automatic check_idle_outputs(input string name);
        check($sformatf("%s rsp_valid", name), 32'(rsp_valid), 32'd0);
        check($sformatf("%s result", name), rsp_res, 32'd0);
        check($sformatf("%s result_hi", name), rsp_hi, 32'd0);
        check($sformatf("%s req_ready", name), 32'(req_ready), 32'd1);
    endtask

    typedef struct {
        sha2_op_t    op;
        logic        fuse;
        logic [31:0] a, b, exp_lo, exp_hi;
        int unsigned lat, stall;
    } vec_t;

    vec_t vecs[7];

    initial begin
        bit          ok;
        int unsigned n;
        logic [63:0] exp;
        sha2_op_t    rop;
        logic        rfuse;
        logic [31:0] ra, rb;

        rst_n = 1'b0; kill = 1'b0; req_valid = 1'b0; nb_req_valid = 1'b0; rsp_ready = 1'b0;
        req_op = SHA2_SIG0; req_fuse = 1'b0; op_a = '0; op_b = '0;

        vecs[0] = '{SHA2_SIG0,  1'b0, 32'h1, 32'h0, 32'h02004000, 32'h0, 2, 0};
        vecs[1] = '{SHA2_SUM0,  1'b0, 32'h1, 32'h0, 32'h40080400, 32'h0, 2, 5};
        vecs[2] = '{SHA2_SIG0L, 1'b1, 32'h0, 32'h1, 32'h83000000, 32'h0, FuseEn ? 3 : 2, 0};
        vecs[3] = '{SHA2_SIG1,  1'b1, 32'h1, 32'h0, 32'h0000A000, 32'h0, 2, 0};
        vecs[4] = '{SHA2_SUM0R, 1'b1, 32'h1, 32'h0, 32'h42000000,
                    FuseEn ? 32'h10 : 32'h0, FuseEn ? 3 : 2, 1};
        vecs[5] = '{SHA2_SUM1,  1'b0, 32'h1, 32'hDEADBEEF, 32'h04200080, 32'h0, 2, 1};
        vecs[6] = '{SHA2_SIG0H, 1'b1, 32'h0, 32'h1, 32'h81000000, 32'h0, 2, 0};

        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].fuse, vecs[i].a, vecs[i].b,
                  vecs[i].exp_lo, vecs[i].exp_hi, vecs[i].lat, vecs[i].stall);
        end

        b2b_seq(1'b0);
        @(negedge clk);
        b2b_seq(1'b1);
        @(negedge clk);

        // Kill in IDLE with a request presented: it must not be taken.
        req_valid = 1'b1; req_op = SHA2_SIG0; req_fuse = 1'b0; op_a = 32'h1; kill = 1'b1;
        #1;
        check("kill idle ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        kill = 1'b0; req_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("kill idle no rsp c%0d", c), 32'(rsp_valid), 32'd0);
        end

        // Kill mid-op (CALC_HI when fusion is built in, CALC_LO otherwise).
        issue(SHA2_SIG0L, 1'b1, 32'h0, 32'h1, ok);
        check("kill issue", 32'(ok), 32'd1);
        if (FuseEn) @(negedge clk);
        kill = 1'b1; req_valid = 1'b1;
        #1;
        check("kill busy ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        kill = 1'b0; req_valid = 1'b0;
        check("kill next valid", 32'(rsp_valid), 32'd0);
        #1;
        check("kill next idle", 32'(req_ready), 32'd1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("kill no rsp c%0d", c), 32'(rsp_valid), 32'd0);
        end

        // Reset while holding a response.
        issue(SHA2_SUM0R, 1'b1, 32'h1, 32'h0, ok);
        check("rst issue", 32'(ok), 32'd1);
        n = 1;
        while (!rsp_valid && n < 8) begin
            @(negedge clk); n++;
        end
        check("rst in resp", 32'(rsp_valid), 32'd1);
        exp = ref_rsp(SHA2_SUM0R, 1'b1, 32'h1, 32'h0);
        check("rst pre hi", rsp_hi, exp[63:32]);
        rst_n = 1'b0;
        @(negedge clk);
        check_idle_outputs("rst during");
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("rst after");

        for (int i = 0; i < 40; i++) begin
            rop   = sha2_op_t'(4'($urandom_range(0, 9)));
            rfuse = 1'($urandom);
            ra    = $urandom;
            rb    = $urandom;
            exp   = ref_rsp(rop, rfuse, ra, rb);
            do_op($sformatf("rnd%0d", i), rop, rfuse, ra, rb, exp[31:0], exp[63:32],
                  ref_fused(rop, rfuse) ? 3 : 2, $urandom_range(0, 2));
            repeat ($urandom_range(0, 1)) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
